// File: rtl/multicycle_alu.sv
// multicycle_alu: handshaked ALU between decode and writeback.
// Ten single-cycle operations are registered with one cycle of latency.
// Unsigned multiply (low/high word) and unsigned divide/remainder run
// iteratively, one step per cycle, for DATA_WIDTH cycles.
// At most one request is in flight; in_ready is high only in IDLE.
module multicycle_alu #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] operand_a,
  input  logic [DATA_WIDTH-1:0] operand_b,
  input  logic [3:0]            alu_operation,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] alu_result,
  output logic                  is_zero,
  output logic                  busy
);

  localparam int SHAMT_W = $clog2(DATA_WIDTH);
  localparam int CNT_W   = $clog2(DATA_WIDTH + 1);

  typedef enum logic [3:0] {
    OP_ADD   = 4'b0000,
    OP_SUB   = 4'b0001,
    OP_AND   = 4'b0010,
    OP_OR    = 4'b0011,
    OP_XOR   = 4'b0100,
    OP_SLL   = 4'b0101,
    OP_SRL   = 4'b0110,
    OP_SRA   = 4'b0111,
    OP_SLT   = 4'b1000,
    OP_SLTU  = 4'b1001,
    OP_MUL   = 4'b1010,
    OP_MULHU = 4'b1011,
    OP_DIVU  = 4'b1100,
    OP_REMU  = 4'b1101,
    OP_RSV0  = 4'b1110,
    OP_RSV1  = 4'b1111
  } op_t;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    COMPUTE = 2'b01,
    DONE    = 2'b10
  } state_t;

  state_t                state;
  op_t                   op_in;
  op_t                   op_q;
  logic [CNT_W-1:0]      counter;

  // Iterative datapath registers.
  // Multiply: opnd_q = multiplicand, {work_hi, work_lo} = partial product
  //           with the multiplier shifting out of work_lo.
  // Divide:   opnd_q = divisor, work_hi = partial remainder,
  //           work_lo = dividend shifting out / quotient shifting in.
  logic [DATA_WIDTH-1:0] opnd_q;
  logic [DATA_WIDTH-1:0] work_hi;
  logic [DATA_WIDTH-1:0] work_lo;

  logic [SHAMT_W-1:0]    shamt;
  logic [DATA_WIDTH-1:0] simple_res;
  logic                  start_iter;
  logic                  start_mul;
  logic                  op_q_is_mul;

  logic [DATA_WIDTH:0]   mul_sum;
  logic [DATA_WIDTH:0]   div_part;
  logic [DATA_WIDTH:0]   div_diff;
  logic                  div_ge;
  logic [DATA_WIDTH-1:0] next_hi;
  logic [DATA_WIDTH-1:0] next_lo;
  logic [DATA_WIDTH-1:0] iter_res;

  assign op_in       = op_t'(alu_operation);
  assign shamt       = operand_b[SHAMT_W-1:0];
  assign op_q_is_mul = (op_q == OP_MUL) || (op_q == OP_MULHU);

  // Decode which incoming opcodes take the iterative path.
  always_comb begin
    start_iter = 1'b0;
    start_mul  = 1'b0;
    case (op_in)
      OP_MUL, OP_MULHU: begin
        start_iter = 1'b1;
        start_mul  = 1'b1;
      end
      OP_DIVU, OP_REMU: start_iter = 1'b1;
      default: begin
        start_iter = 1'b0;
        start_mul  = 1'b0;
      end
    endcase
  end

  // Single-cycle operation results, taken straight from the request inputs.
  always_comb begin
    simple_res = '0;
    case (op_in)
      OP_ADD:  simple_res = operand_a + operand_b;
      OP_SUB:  simple_res = operand_a - operand_b;
      OP_AND:  simple_res = operand_a & operand_b;
      OP_OR:   simple_res = operand_a | operand_b;
      OP_XOR:  simple_res = operand_a ^ operand_b;
      OP_SLL:  simple_res = operand_a << shamt;
      OP_SRL:  simple_res = operand_a >> shamt;
      OP_SRA:  simple_res = $signed(operand_a) >>> shamt;
      OP_SLT:  simple_res = {{(DATA_WIDTH-1){1'b0}},
                             ($signed(operand_a) < $signed(operand_b))};
      OP_SLTU: simple_res = {{(DATA_WIDTH-1){1'b0}}, (operand_a < operand_b)};
      default: simple_res = '0;
    endcase
  end

  // One shift-add or restoring subtract-shift step, and the value to
  // publish when that step is the last one. A zero divisor always passes
  // the compare, giving an all-ones quotient and a remainder equal to the
  // dividend without any dedicated path.
  always_comb begin
    mul_sum  = {1'b0, work_hi} + (work_lo[0] ? {1'b0, opnd_q} : '0);
    div_part = {work_hi, work_lo[DATA_WIDTH-1]};
    div_ge   = (div_part >= {1'b0, opnd_q});
    div_diff = div_part - {1'b0, opnd_q};
    if (op_q_is_mul) begin
      next_hi = mul_sum[DATA_WIDTH:1];
      next_lo = {mul_sum[0], work_lo[DATA_WIDTH-1:1]};
    end else begin
      next_hi = div_ge ? div_diff[DATA_WIDTH-1:0] : div_part[DATA_WIDTH-1:0];
      next_lo = {work_lo[DATA_WIDTH-2:0], div_ge};
    end
    case (op_q)
      OP_MUL, OP_DIVU: iter_res = next_lo;
      default:         iter_res = next_hi;
    endcase
  end

  // Control FSM with registered handshake outputs and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      counter    <= '0;
      alu_result <= '0;
      is_zero    <= 1'b1;
      op_q       <= OP_ADD;
      opnd_q     <= '0;
      work_hi    <= '0;
      work_lo    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_q     <= op_in;
            in_ready <= 1'b0;
            if (start_iter) begin
              state   <= COMPUTE;
              busy    <= 1'b1;
              counter <= CNT_W'(DATA_WIDTH);
              work_hi <= '0;
              if (start_mul) begin
                opnd_q  <= operand_a;
                work_lo <= operand_b;
              end else begin
                opnd_q  <= operand_b;
                work_lo <= operand_a;
              end
            end else begin
              state      <= DONE;
              out_valid  <= 1'b1;
              alu_result <= simple_res;
              is_zero    <= (simple_res == '0);
            end
          end
        end

        COMPUTE: begin
          work_hi <= next_hi;
          work_lo <= next_lo;
          counter <= counter - CNT_W'(1);
          if (counter == CNT_W'(1)) begin
            state      <= DONE;
            busy       <= 1'b0;
            out_valid  <= 1'b1;
            alu_result <= iter_res;
            is_zero    <= (iter_res == '0);
          end
        end

        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end

        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_alu.sv
// tb_multicycle_alu: directed vectors with a result scoreboard.
// Stimulus pushes the expected result when it issues a request; a monitor
// pops and compares on every out_valid && out_ready handshake.
module tb_multicycle_alu;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] operand_a;
  logic [W-1:0] operand_b;
  logic [3:0]   alu_operation;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] alu_result;
  logic         is_zero;
  logic         busy;

  int           n_checks = 0;
  int           n_fail   = 0;
  logic [W-1:0] exp_q[$];

  multicycle_alu #(.DATA_WIDTH(W)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .operand_a     (operand_a),
    .operand_b     (operand_b),
    .alu_operation (alu_operation),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .alu_result    (alu_result),
    .is_zero       (is_zero),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input bit ok, input string name,
                       input logic [W-1:0] act, input logic [W-1:0] req);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  // Scoreboard monitor: compare every delivered result in issue order.
  always @(negedge clk) begin : monitor
    logic [W-1:0] e;
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check(1'b0, "unexpected_result", alu_result, '0);
      end else begin
        e = exp_q.pop_front();
        check(alu_result == e, "result", alu_result, e);
        check(is_zero == (e == '0), "is_zero", W'(is_zero), W'(e == '0));
      end
    end
  end

  // Issue one request, scramble the inputs after acceptance, then measure
  // the latency to out_valid and the number of busy cycles.
  task automatic send(input logic [3:0] op, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic [W-1:0] exp_r,
                      input int exp_lat, input string name);
    int t;
    int lat;
    int busy_n;
    t = 0;
    while (!in_ready && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    check(in_ready == 1'b1, {name, "_in_ready"}, W'(in_ready), 1);
    operand_a     = a;
    operand_b     = b;
    alu_operation = op;
    in_valid      = 1'b1;
    exp_q.push_back(exp_r);
    @(posedge clk); #1;
    in_valid      = 1'b0;
    operand_a     = ~a;
    operand_b     = ~b;
    alu_operation = 4'hF;
    lat    = 1;
    busy_n = 0;
    while (!out_valid && lat < 200) begin
      if (busy) busy_n++;
      @(posedge clk); #1;
      lat++;
    end
    check(lat == exp_lat, {name, "_latency"}, W'(lat), W'(exp_lat));
    check(busy_n == exp_lat - 1, {name, "_busy_cycles"}, W'(busy_n), W'(exp_lat - 1));
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    int t;
    reset         = 1'b1;
    in_valid      = 1'b0;
    operand_a     = '0;
    operand_b     = '0;
    alu_operation = 4'h0;
    out_ready     = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check(out_valid == 1'b0, "rst_out_valid", W'(out_valid), 0);
    check(busy == 1'b0, "rst_busy", W'(busy), 0);
    check(alu_result == '0, "rst_result", alu_result, 0);
    check(is_zero == 1'b1, "rst_is_zero", W'(is_zero), 1);
    reset = 1'b0;
    #1;
    check(in_ready == 1'b1, "rst_in_ready", W'(in_ready), 1);

    // Add with signed overflow, then in_ready back the following cycle.
    send(4'h0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1, "add");
    @(posedge clk); #1;
    check(in_ready == 1'b1, "add_in_ready_after", W'(in_ready), 1);
    check(out_valid == 1'b0, "add_out_valid_after", W'(out_valid), 0);

    // Arithmetic shift with the consumer stalling for five cycles.
    out_ready = 1'b0;
    send(4'h7, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 1, "sra");
    for (int i = 0; i < 5; i++) begin
      check(alu_result == 32'hF800_0000, "sra_stall_result", alu_result, 32'hF800_0000);
      check(in_ready == 1'b0, "sra_stall_in_ready", W'(in_ready), 0);
      check(out_valid == 1'b1, "sra_stall_out_valid", W'(out_valid), 1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;

    // Iterative multiply and divide.
    send(4'hA, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33, "mul_max");
    send(4'hB, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, "mulhu_max");
    send(4'hA, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 33, "mul_lo_zero");
    send(4'hB, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 33, "mulhu_one");
    send(4'hC, 32'd100, 32'd7, 32'd14, 33, "divu_100_7");
    send(4'hD, 32'd100, 32'd7, 32'd2, 33, "remu_100_7");
    send(4'hC, 32'd5, 32'd0, 32'hFFFF_FFFF, 33, "divu_by_zero");
    send(4'hD, 32'd5, 32'd0, 32'd5, 33, "remu_by_zero");
    send(4'hC, 32'h8000_0000, 32'h0000_0010, 32'h0800_0000, 33, "divu_big");
    send(4'hD, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 33, "remu_big");

    // Remaining single-cycle operations.
    send(4'h1, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1, "sub_wrap");
    send(4'h2, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1, "and");
    send(4'h3, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1, "or");
    send(4'h4, 32'hAAAA_AAAA, 32'hAAAA_AAAA, 32'h0000_0000, 1, "xor_zero");
    send(4'h5, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 1, "sll_31");
    send(4'h6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0001, 1, "srl_31");
    send(4'h8, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1, "slt_neg");
    send(4'h9, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1, "sltu_big");
    send(4'hE, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000, 1, "op_e");

    // Reset asserted mid-divide discards the operation asynchronously.
    t = 0;
    while (!in_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    operand_a     = 32'd1000;
    operand_b     = 32'd3;
    alu_operation = 4'hC;
    in_valid      = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check(busy == 1'b1, "divu_busy_before_reset", W'(busy), 1);
    reset = 1'b1;
    #1;
    check(out_valid == 1'b0, "midrst_out_valid", W'(out_valid), 0);
    check(busy == 1'b0, "midrst_busy", W'(busy), 0);
    check(alu_result == '0, "midrst_result", alu_result, 0);
    check(is_zero == 1'b1, "midrst_is_zero", W'(is_zero), 1);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check(in_ready == 1'b1, "midrst_in_ready", W'(in_ready), 1);
    send(4'h1, 32'd3, 32'd3, 32'd0, 1, "sub_zero");

    // Inputs change mid-compute while in_valid stays high: the pending
    // 1111 and sltu requests are taken only once the block is idle again.
    t = 0;
    while (!in_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    operand_a     = 32'd7;
    operand_b     = 32'd6;
    alu_operation = 4'hA;
    in_valid      = 1'b1;
    exp_q.push_back(32'd42);
    @(posedge clk); #1;
    operand_a     = 32'hDEAD_BEEF;
    operand_b     = 32'h1234_5678;
    alu_operation = 4'hF;
    exp_q.push_back(32'd0);
    t = 0;
    while (!in_ready && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    check(t == 33, "held_mul_idle_wait", W'(t), 33);
    @(posedge clk); #1;
    check(out_valid == 1'b1, "op_f_accepted", W'(out_valid), 1);
    check(in_ready == 1'b0, "op_f_in_ready", W'(in_ready), 0);
    operand_a     = 32'd1;
    operand_b     = 32'd2;
    alu_operation = 4'h9;
    exp_q.push_back(32'd1);
    t = 0;
    while (!in_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    check(t == 1, "held_op_f_idle_wait", W'(t), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check(out_valid == 1'b1, "sltu_accepted", W'(out_valid), 1);
    repeat (3) @(posedge clk);
    #1;
    check(exp_q.size() == 0, "scoreboard_drained", W'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
